// File: rtl/mixer_pkg.sv
// Shared types and helpers for the time-multiplexed resistive mixer.
// Weights are Q0.16 conductance ratios; samples are unsigned 16-bit.
package mixer_pkg;

    typedef logic [15:0] sample_t;
    typedef logic [15:0] weight_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        NORM
    } state_t;

    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    // Accumulator wide enough that NUM_INPUTS full-scale products never wrap.
    function automatic int acc_width(input int n);
        return 32 + $clog2(n);
    endfunction

endpackage

// File: rtl/weighted_accumulator.sv
// Registered multiply-add: one 16x16 product folded into a wide
// accumulator per enabled cycle, with synchronous clear.
module weighted_accumulator
    import mixer_pkg::*;
#(
    parameter int AW = 34
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  weight_t       i_w,
    input  sample_t       i_s,
    output logic [AW-1:0] o_acc
);

    logic [31:0]   w_prod;
    logic [AW-1:0] r_acc;

    assign w_prod = 32'(i_w) * 32'(i_s);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + AW'(w_prod);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/resistive_mixer_sequencer.sv
// N-way resistive mixer: snapshots inputs on sample_en, runs one MAC per
// channel on a shared multiplier, then normalises and saturates.
module resistive_mixer_sequencer
    import mixer_pkg::*;
#(
    parameter int      NUM_INPUTS     = 4,
    parameter weight_t DEFAULT_WEIGHT = weight_t'(65535 / NUM_INPUTS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                sample_en,
    input  logic [NUM_INPUTS-1:0][15:0]         inputs,
    input  logic                                cfg_we,
    input  logic [$clog2(NUM_INPUTS)-1:0]       cfg_addr,
    input  logic [15:0]                         cfg_wdata,
    output logic [15:0]                         out,
    output logic                                out_valid,
    output logic                                busy,
    output logic                                overrun
);

    localparam int IDXW = $clog2(NUM_INPUTS);
    localparam int AW   = acc_width(NUM_INPUTS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_INPUTS - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [IDXW-1:0]              r_idx;
    logic [NUM_INPUTS-1:0][15:0]  r_samp;
    logic [NUM_INPUTS-1:0][15:0]  r_pend;
    logic [NUM_INPUTS-1:0][15:0]  r_act;
    logic [NUM_INPUTS-1:0][15:0]  w_pend_nxt;
    logic [15:0]                  r_out;
    logic                         r_ovr;

    logic          w_accept;
    logic          w_cfg_ok;
    logic          w_en;
    logic [AW-1:0] w_acc;
    logic [AW-1:0] w_shift;
    logic [15:0]   w_sat;

    assign w_accept = sample_en && (r_state == IDLE);
    assign w_cfg_ok = cfg_we && (int'(cfg_addr) < NUM_INPUTS);
    assign w_en     = (r_state == ACCUM);

    // Merge a same-cycle write so an accepted sample sees it in the copy.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_cfg_ok) begin
            w_pend_nxt[cfg_addr] = cfg_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (sample_en) w_state_nxt = ACCUM;
            ACCUM:   if (r_idx == LAST_IDX) w_state_nxt = NORM;
            NORM:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_samp  <= '0;
            r_pend  <= {NUM_INPUTS{DEFAULT_WEIGHT}};
            r_act   <= {NUM_INPUTS{DEFAULT_WEIGHT}};
            r_out   <= '0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_ovr   <= sample_en && (r_state != IDLE);
            if (w_accept) begin
                r_samp <= inputs;
                r_act  <= w_pend_nxt;
                r_idx  <= '0;
            end else if (r_state == ACCUM) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == NORM) begin
                r_out <= w_sat;
            end
        end
    end

    weighted_accumulator #(
        .AW(AW)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_accept),
        .i_en  (w_en),
        .i_w   (r_act[r_idx]),
        .i_s   (r_samp[r_idx]),
        .o_acc (w_acc)
    );

    assign w_shift = w_acc >> 16;
    assign w_sat   = (w_shift > AW'(SAT_MAX)) ? SAT_MAX : w_shift[15:0];

    // The fresh result is shown during NORM so it lines up with out_valid.
    assign out       = (r_state == NORM) ? w_sat : r_out;
    assign out_valid = (r_state == NORM);
    assign busy      = (r_state != IDLE);
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_resistive_mixer_sequencer.sv
// Directed bench for the 2-input mixer: latency, double buffering,
// saturation, overrun and mid-mix reset.
module tb_resistive_mixer_sequencer;

    logic             clk = 1'b0;
    logic             reset;
    logic             sample_en;
    logic [1:0][15:0] inputs;
    logic             cfg_we;
    logic [0:0]       cfg_addr;
    logic [15:0]      cfg_wdata;
    logic [15:0]      out;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    int checks = 0;
    int errors = 0;

    resistive_mixer_sequencer #(
        .NUM_INPUTS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .inputs    (inputs),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic a, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Strobe sample_en; returns one cycle later (cycle 1 of the mix).
    task automatic start(input logic [15:0] a, input logic [15:0] b);
        inputs = {b, a};
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
    endtask

    // Bounded wait for out_valid; expects it exactly at cycle 3.
    task automatic wait_valid(input string tag, input int n0,
                              input logic [15:0] exp);
        int n;
        n = n0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_out"}, out, exp);
        tick();
        chk({tag, "_vld_off"}, out_valid, 1'b0);
        chk({tag, "_busy_off"}, busy, 1'b0);
        chk({tag, "_hold"}, out, exp);
    endtask

    initial begin
        reset = 1'b1;
        sample_en = 1'b0;
        inputs = '0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        tick();
        tick();
        chk("rst_out", out, 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        tick();

        // Default weights 32767: 4000*32767>>16 = 1999
        start(16'd1000, 16'd3000);
        chk("basic_busy", busy, 1);
        wait_valid("basic", 1, 16'd1999);

        // Write during busy plus input change: current mix unaffected
        start(16'd1000, 16'd3000);
        inputs = {16'd5000, 16'd5000};
        wr(1'b0, 16'd0);
        wait_valid("dbuf_cur", 2, 16'd1999);
        start(16'd1000, 16'd3000);
        wait_valid("dbuf_next", 1, 16'd1499);

        // 10k/20k divider: 30000*43690>>16 = 19999
        wr(1'b0, 16'd43690);
        wr(1'b1, 16'd21845);
        start(16'd30000, 16'd0);
        wait_valid("resist", 1, 16'd19999);

        // Raw 131068 clamps to full scale
        wr(1'b0, 16'hFFFF);
        wr(1'b1, 16'hFFFF);
        start(16'hFFFF, 16'hFFFF);
        wait_valid("sat", 1, 16'hFFFF);

        // Second strobe one cycle later is rejected: 300*65535>>16 = 299
        start(16'd100, 16'd200);
        inputs = {16'd9000, 16'd9000};
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("ovr_pulse", overrun, 1);
        wait_valid("ovr_mix", 2, 16'd299);
        chk("ovr_clear", overrun, 0);
        for (int i = 0; i < 3; i++) begin
            chk("ovr_no_vld", out_valid, 0);
            tick();
        end
        chk("ovr_out_kept", out, 299);

        // Same-cycle write joins the copy: 3000*65535>>16 = 2999
        inputs = {16'd3000, 16'd1000};
        cfg_we = 1'b1;
        cfg_addr = 1'b0;
        cfg_wdata = 16'd0;
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        cfg_we = 1'b0;
        chk("same_busy", busy, 1);
        tick();
        tick();
        chk("same_vld", out_valid, 1);
        chk("same_out", out, 2999);
        // Strobe in NORM is rejected
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        chk("norm_ovr", overrun, 1);
        chk("norm_busy", busy, 0);
        chk("norm_vld", out_valid, 0);
        chk("norm_hold", out, 2999);

        // Reset during ACCUM aborts the mix
        start(16'd1000, 16'd3000);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_out", out, 0);
        chk("mid_busy0", busy, 0);
        chk("mid_vld", out_valid, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_vld", out_valid, 0);
        end
        start(16'd1000, 16'd3000);
        wait_valid("mid_dflt", 1, 16'd1999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
